// File: rtl/prio_mask_decoder.sv
// Run-time-loadable wildcard decoder: first-match priority table with care masks, registered outputs.
// Optional build macro PRIO_DECODE_HOLD_EN keeps out_code/out_flag/out_idx stable while in_valid is low.
module prio_mask_decoder #(
   parameter int unsigned DATA_W       = 3,
   parameter int unsigned ENTRIES      = 4,
   parameter int unsigned OUT_W        = 3,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DEFAULT_CODE = 2,
   localparam int unsigned IDX_W       = $clog2(ENTRIES)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_en,
   input  logic [DATA_W-1:0] cfg_value,
   input  logic [DATA_W-1:0] cfg_care,
   input  logic [OUT_W-1:0]  cfg_code,
   input  logic              cfg_flag,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic              out_hit,
   output logic [IDX_W-1:0]  out_idx,
   output logic [OUT_W-1:0]  out_code,
   output logic              out_flag,
   output logic [CNT_W-1:0]  miss_count
);

   typedef struct packed {
      logic              en;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] care;
      logic [OUT_W-1:0]  code;
      logic              flag;
   } entry_t;

   localparam logic [OUT_W-1:0] DEF_CODE = OUT_W'(DEFAULT_CODE);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   entry_t             tbl [ENTRIES];
   logic               match_hit;
   logic [IDX_W-1:0]   match_idx;
   logic [OUT_W-1:0]   match_code;
   logic               match_flag;

   // Table write; out-of-range indices match no entry and are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) tbl[i] <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < int'(ENTRIES); i++)
            if (cfg_idx == IDX_W'(i))
               tbl[i] <= '{en: cfg_en, value: cfg_value, care: cfg_care,
                           code: cfg_code, flag: cfg_flag};
      end
   end

   // Scan from the top so the lowest matching index is the last one written.
   always_comb begin
      match_hit  = 1'b0;
      match_idx  = '0;
      match_code = DEF_CODE;
      match_flag = 1'b0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (tbl[i].en && (((in_data ^ tbl[i].value) & tbl[i].care) == '0)) begin
            match_hit  = 1'b1;
            match_idx  = IDX_W'(i);
            match_code = tbl[i].code;
            match_flag = tbl[i].flag;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_hit    <= 1'b0;
         out_idx    <= '0;
         out_code   <= '0;
         out_flag   <= 1'b0;
         miss_count <= '0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         out_hit   <= match_hit;
         out_idx   <= match_idx;
         out_code  <= match_code;
         out_flag  <= match_flag;
         if (!match_hit && miss_count != CNT_MAX)
            miss_count <= miss_count + CNT_W'(1);
      end else begin
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
`ifndef PRIO_DECODE_HOLD_EN
         out_idx   <= '0;
         out_code  <= DEF_CODE;
         out_flag  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_prio_mask_decoder.sv
// Scoreboard bench for prio_mask_decoder: a reference table model predicts each cycle's registered outputs.
module tb_prio_mask_decoder;

   localparam int unsigned ENTRIES = 4;
   localparam int unsigned IDX_W   = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic       cfg_en = 1'b0;
   logic [2:0] cfg_value = '0;
   logic [2:0] cfg_care = '0;
   logic [2:0] cfg_code = '0;
   logic       cfg_flag = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_data = '0;
   logic       out_valid, out_hit, out_flag;
   logic [1:0] out_idx;
   logic [2:0] out_code;
   logic [7:0] miss_count;

   prio_mask_decoder dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_value(cfg_value), .cfg_care(cfg_care), .cfg_code(cfg_code), .cfg_flag(cfg_flag),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_hit(out_hit),
      .out_idx(out_idx), .out_code(out_code), .out_flag(out_flag), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       v;
      logic       h;
      logic [1:0] idx;
      logic [2:0] code;
      logic       f;
      logic [7:0] miss;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference table
   logic       m_en   [ENTRIES];
   logic [2:0] m_val  [ENTRIES];
   logic [2:0] m_care [ENTRIES];
   logic [2:0] m_code [ENTRIES];
   logic       m_flag [ENTRIES];
   exp_t       m_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // One clock: drive at negedge, predict, push, then pop and compare after the edge.
   task automatic step(input logic rst, input logic we, input logic [1:0] widx, input logic wen,
                       input logic [2:0] wval, input logic [2:0] wcare, input logic [2:0] wcode,
                       input logic wflag, input logic iv, input logic [2:0] id, input string tag);
      exp_t e;
      logic hit;
      int   win;
      @(negedge clock);
      reset = rst; cfg_we = we; cfg_idx = widx; cfg_en = wen; cfg_value = wval;
      cfg_care = wcare; cfg_code = wcode; cfg_flag = wflag; in_valid = iv; in_data = id;
      e = m_out;
      if (rst) begin
         e = '{v: 1'b0, h: 1'b0, idx: 2'd0, code: 3'd0, f: 1'b0, miss: 8'd0};
         for (int i = 0; i < int'(ENTRIES); i++) begin
            m_en[i] = 1'b0; m_val[i] = '0; m_care[i] = '0; m_code[i] = '0; m_flag[i] = 1'b0;
         end
      end else begin
         hit = 1'b0; win = 0;
         for (int i = 0; i < int'(ENTRIES); i++)
            if (!hit && m_en[i] && (((id ^ m_val[i]) & m_care[i]) == 3'd0)) begin
               hit = 1'b1; win = i;
            end
         e.v = iv;
         e.h = iv & hit;
         if (iv) begin
            e.idx  = hit ? 2'(win) : 2'd0;
            e.code = hit ? m_code[win] : 3'd2;
            e.f    = hit ? m_flag[win] : 1'b0;
            if (!hit && e.miss != 8'hFF) e.miss = e.miss + 8'd1;
         end else begin
`ifndef PRIO_DECODE_HOLD_EN
            e.idx = 2'd0; e.code = 3'd2; e.f = 1'b0;
`endif
         end
         if (we && int'(widx) < int'(ENTRIES)) begin
            m_en[widx] = wen; m_val[widx] = wval; m_care[widx] = wcare;
            m_code[widx] = wcode; m_flag[widx] = wflag;
         end
      end
      m_out = e;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 32'(out_valid), 32'(e.v));
         check({tag, "_hit"},   32'(out_hit),   32'(e.h));
         check({tag, "_idx"},   32'(out_idx),   32'(e.idx));
         check({tag, "_code"},  32'(out_code),  32'(e.code));
         check({tag, "_flag"},  32'(out_flag),  32'(e.f));
         check({tag, "_miss"},  32'(miss_count), 32'(e.miss));
      end
   endtask

   task automatic dec(input logic [2:0] id, input string tag);
      step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, id, tag);
   endtask

   task automatic wr(input logic [1:0] widx, input logic wen, input logic [2:0] wval,
                     input logic [2:0] wcare, input logic [2:0] wcode, input logic wflag,
                     input string tag);
      step(1'b0, 1'b1, widx, wen, wval, wcare, wcode, wflag, 1'b0, 3'd0, tag);
   endtask

   initial begin
      m_out = '{v: 1'b0, h: 1'b0, idx: 2'd0, code: 3'd0, f: 1'b0, miss: 8'd0};
      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, "reset");
      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, "reset2");
      dec(3'b101, "empty_miss");

      wr(2'd0, 1'b1, 3'b100, 3'b110, 3'd5, 1'b1, "wr_e0");
      wr(2'd1, 1'b1, 3'b001, 3'b101, 3'd2, 1'b0, "wr_e1");
      dec(3'b101, "hit_e0");
      dec(3'b011, "hit_e1");
      dec(3'b000, "miss_b");

      // Make e1 overlap e0 on 3'b100, then disable e0 while decoding.
      wr(2'd1, 1'b1, 3'b100, 3'b100, 3'd6, 1'b0, "wr_e1b");
      dec(3'b100, "overlap");
      step(1'b0, 1'b1, 2'd0, 1'b0, 3'b100, 3'b110, 3'd5, 1'b1, 1'b1, 3'b100, "wr_dec_same");
      dec(3'b100, "after_disable");

      wr(2'd0, 1'b1, 3'b100, 3'b110, 3'd5, 1'b1, "wr_e0c");
      wr(2'd3, 1'b1, 3'b000, 3'b000, 3'd7, 1'b1, "wr_e3_all");
      dec(3'b101, "hit_code5");
      step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, "idle_after_hit");
      dec(3'b010, "catch_all");

      for (int k = 0; k < 60; k++)
         step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom), 3'($urandom),
              3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
              3'($urandom), "random");

      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, "reset_sat");
      for (int k = 0; k < 260; k++) dec(3'($urandom), "saturate");

      wr(2'd2, 1'b1, 3'b000, 3'b000, 3'd4, 1'b1, "wr_e2_all");
      dec(3'b111, "pre_reset_hit");
      step(1'b1, 1'b1, 2'd0, 1'b1, 3'b000, 3'b000, 3'd3, 1'b1, 1'b1, 3'b111, "reset_mid");
      dec(3'b111, "post_reset_miss");
      dec(3'b000, "post_reset_miss2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
